adder_4bit: RTL and testbench

- Parameterised ripple-carry binary adder with carry-in and carry-out, default 4 bits.
- Computes s = a + b + cin. Results are registered on the single clock edge, with status flags.
- Used as the arithmetic leaf of the datapath. Bench drives operands and carry-in, then checks sum and carry-out.

---
 rtl/adder_pkg.sv | 10 +
 rtl/adder_4bit_if.sv | 30 +++
 rtl/full_adder.sv | 15 +
 rtl/adder_4bit.sv | 48 ++++
 tb/tb_adder_4bit.sv | 131 +++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and types for the ripple-carry adder leaf.
// Pure declarations: no latency, no flow control.
// sum_t is the carry-extended result used when checking {cout, s}.
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 4;

    typedef logic [ADDER_DEFAULT_WIDTH:0] sum_t;

endpackage

// File: rtl/adder_4bit_if.sv
// Operand/result bundle between a datapath producer and the adder leaf.
// Latency set by the attached adder (1 cycle); no backpressure signals exist.
// master drives operands and reads results, slave is the adder side.
interface adder_4bit_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, cin, a, b,
        input  s, cout, overflow, zero, out_valid
    );

    modport slave (
        input  in_valid, cin, a, b,
        output s, cout, overflow, zero, out_valid
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell, one link of the ripple chain.
// Purely combinational, zero latency.
// No flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder s = a + b + cin with cout/overflow/zero flags.
// Latency 1 cycle, one operation per cycle.
// No backpressure: results hold when in_valid is low, out_valid follows in_valid.
module adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    adder_4bit_if.slave  bus
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s         <= '0;
            bus.cout      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            // Flags travel with the sum so they stay coherent while holding.
            if (bus.in_valid) begin
                bus.s        <= sum;
                bus.cout     <= c[WIDTH];
                bus.overflow <= c[WIDTH] ^ c[WIDTH-1];
                bus.zero     <= (sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_adder_4bit.sv
// Randomized and directed checks of adder_4bit against an arithmetic model.
module tb_adder_4bit;
    import adder_pkg::*;

    localparam int W = ADDER_DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst;

    adder_4bit_if #(.WIDTH(W)) bus ();

    adder_4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_s;
    logic         m_cout;
    logic         m_ov;
    logic         m_zero;
    logic         m_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic r, input logic v, input logic c,
                         input logic [W-1:0] aa, input logic [W-1:0] bb);
        sum_t full;
        int   sa, sb, ss;
        if (r) begin
            m_s = '0; m_cout = 1'b0; m_ov = 1'b0; m_zero = 1'b1; m_vld = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                full   = sum_t'(aa) + sum_t'(bb) + sum_t'(c);
                m_s    = full[W-1:0];
                m_cout = full[W];
                sa = int'(aa); if (aa[W-1]) sa -= (1 << W);
                sb = int'(bb); if (bb[W-1]) sb -= (1 << W);
                ss = sa + sb + int'(c);
                m_ov   = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
                m_zero = (m_s == '0);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic c,
                         input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
        rst          = r;
        bus.in_valid = v;
        bus.cin      = c;
        bus.a        = aa;
        bus.b        = bb;
        @(posedge clk);
        model(r, v, c, aa, bb);
        @(negedge clk);
        chk({tag, ".s"},         32'(bus.s),         32'(m_s));
        chk({tag, ".cout"},      32'(bus.cout),      32'(m_cout));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ov));
        chk({tag, ".zero"},      32'(bus.zero),      32'(m_zero));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    initial begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
        @(negedge clk);

        // Reset with random inputs present.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd(), rnd(), "reset");
        chk("reset.zero_lit", 32'(bus.zero), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, W'(0), W'(1), "first");
        chk("first.s_lit", 32'(bus.s), 32'd1);

        // Carry wrap and all-ones boundaries.
        cycle(1'b0, 1'b1, 1'b0, W'(15), W'(1), "wrap");
        chk("wrap.cout_lit", 32'(bus.cout), 32'd1);
        chk("wrap.zero_lit", 32'(bus.zero), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, W'(15), W'(15), "ones");
        chk("ones.s_lit", 32'(bus.s), 32'hf);

        // Signed overflow boundaries.
        cycle(1'b0, 1'b1, 1'b0, W'(7), W'(1), "maxpos");
        chk("maxpos.s_lit", 32'(bus.s), 32'h8);
        chk("maxpos.ov_lit", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, W'(8), W'(8), "minneg");
        chk("minneg.cout_lit", 32'(bus.cout), 32'd1);
        chk("minneg.ov_lit", 32'(bus.overflow), 32'd1);

        // Exhaustive, back-to-back.
        for (int ci = 0; ci < 2; ci++)
            for (int i = 0; i < 256; i++)
                cycle(1'b0, 1'b1, 1'(ci), W'(i >> 4), W'(i & 15), "exh");

        // Hold while in_valid is low.
        cycle(1'b0, 1'b1, 1'b0, W'(3), W'(4), "hold_load");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd(), rnd(), "hold");
            chk("hold.s_lit", 32'(bus.s), 32'h7);
        end

        // Reset wins over a valid operation, which is discarded.
        cycle(1'b1, 1'b1, 1'b0, W'(5), W'(6), "rst_drop");
        chk("rst_drop.s_lit", 32'(bus.s), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, W'(5), W'(6), "rst_drop_after");

        // Random mix of valid gaps and occasional resets.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), rnd(), rnd(), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
